// File: rtl/uart_tx_module.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1 or 2
// stop bits. A one-byte holding register lets the producer queue the next
// byte while the current frame shifts, so consecutive frames have no gap.
module uart_tx_module #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_byte,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       data_line,
  output logic       busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // Parity bit for a byte: mode 2 is odd parity, anything else even.
  function automatic logic parity_bit(input logic [7:0] b, input int mode);
    logic p;
    if (mode == 2) begin
      p = ~^b;
    end else begin
      p = ^b;
    end
    return p;
  endfunction

  state_t           state_r, state_s;
  logic [7:0]       hold_r, hold_s;
  logic             hold_full_r, hold_full_s;
  logic [7:0]       shift_r, shift_s;
  logic             par_r, par_s;
  logic [2:0]       bit_idx_r, bit_idx_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             data_line_r, data_line_s;
  logic             data_ready_r, data_ready_s;
  logic             busy_r, busy_s;
  logic             tx_done_r, tx_done_s;
  logic             bit_end_s;
  logic             load_s;

  // Next-state, datapath and next-output computation for the frame sequencer.
  always_comb begin
    state_s     = state_r;
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    shift_s     = shift_r;
    par_s       = par_r;
    bit_idx_s   = bit_idx_r;
    cnt_s       = cnt_r;
    load_s      = 1'b0;
    bit_end_s   = (cnt_r == CNT_LAST);

    case (state_r)
      IDLE: begin
        bit_idx_s = 3'd0;
        if (hold_full_r) begin
          load_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s   = DATA;
          bit_idx_s = 3'd0;
        end else begin
          state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
            state_s   = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      PAR: begin
        if (bit_end_s) begin
          state_s   = STOP;
          bit_idx_s = 3'd0;
        end else begin
          state_s = PAR;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (bit_idx_r == STOP_LAST) begin
            bit_idx_s = 3'd0;
            if (hold_full_r) begin
              load_s = 1'b1;
            end else begin
              state_s = IDLE;
            end
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          state_s = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        bit_idx_s = 3'd0;
      end
    endcase

    // Bit timer runs only inside a frame and wraps at every bit boundary.
    if ((state_r != IDLE) && !bit_end_s) begin
      cnt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_s = '0;
    end

    // Loading drains the holding register; accepting fills it. Loading needs
    // a full register and accepting an empty one, so they never coincide.
    if (load_s) begin
      shift_s     = hold_r;
      par_s       = parity_bit(hold_r, PARITY);
      hold_full_s = 1'b0;
      state_s     = START;
      bit_idx_s   = 3'd0;
    end else if (data_valid && !hold_full_r) begin
      hold_s      = data_byte;
      hold_full_s = 1'b1;
    end else begin
      hold_full_s = hold_full_r;
    end

    // Outputs are registered, so they are derived from the next state.
    case (state_s)
      START:   data_line_s = 1'b0;
      DATA:    data_line_s = shift_s[0];
      PAR:     data_line_s = par_s;
      default: data_line_s = 1'b1;
    endcase
    tx_done_s    = (state_s == STOP) && (cnt_s == CNT_LAST) && (bit_idx_s == STOP_LAST);
    busy_s       = (state_s != IDLE) || hold_full_s;
    data_ready_s = !hold_full_s;
  end

  // State, datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      hold_r       <= 8'h00;
      hold_full_r  <= 1'b0;
      shift_r      <= 8'h00;
      par_r        <= 1'b0;
      bit_idx_r    <= 3'd0;
      cnt_r        <= '0;
      data_line_r  <= 1'b1;
      data_ready_r <= 1'b1;
      busy_r       <= 1'b0;
      tx_done_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      hold_r       <= hold_s;
      hold_full_r  <= hold_full_s;
      shift_r      <= shift_s;
      par_r        <= par_s;
      bit_idx_r    <= bit_idx_s;
      cnt_r        <= cnt_s;
      data_line_r  <= data_line_s;
      data_ready_r <= data_ready_s;
      busy_r       <= busy_s;
      tx_done_r    <= tx_done_s;
    end
  end

  assign data_line  = data_line_r;
  assign data_ready = data_ready_r;
  assign busy       = busy_r;
  assign tx_done    = tx_done_r;

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
- UART transmitter; the counterpart of uart_rx_module. Serialises bytes onto data_line as 8 data bits, LSB first, with optional parity and 1 or 2 stop bits.
- A one-byte holding register lets the upstream producer queue the next byte while the current frame is shifting, so back-to-back frames go out with no idle gap.
- Sits between on-board logic (command/telemetry packer) and the radio/host UART pin.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); integer >= 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_byte  in  8  byte to transmit; sampled when data_valid && data_ready.
- data_valid  in  1  producer has a byte on data_byte.
- data_ready  out  1  holding register empty; a byte can be accepted this cycle.
- data_line  out  1  serial TX line; idles high.
- busy  out  1  high while a frame is shifting or the holding register is full.
- tx_done  out  1  one-cycle pulse on the last clock of each frame's final stop bit.

Behaviour:
- Reset (async assert, release on any edge): data_line=1, data_ready=1, busy=0, tx_done=0, state=IDLE. The holding register is emptied and all counters are cleared. A reset mid-frame aborts the frame; data_line goes high immediately and the partial byte is discarded.
- All outputs are registered. data_ready = !hold_full.
- Accept: on an edge with data_valid && data_ready, hold <= data_byte and hold_full <= 1. data_valid while data_ready=0 is ignored; the producer must hold the byte until it is accepted.
- State machine has five states: IDLE, START, DATA, PAR, STOP.
  - IDLE: data_line=1. If hold_full, on the next edge load the shift register from hold, clear hold_full, go to START. First start-bit clock is therefore 1 cycle after the accept edge.
  - START: data_line=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: data_line = shift[0]; after each CLKS_PER_BIT cycles, shift right and increment the bit index (0..7). After bit 7, go to PAR if PARITY != 0, else STOP.
  - PAR: data_line = ^byte for even parity, ~^byte for odd; held CLKS_PER_BIT cycles, then STOP.
  - STOP: data_line=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 on the last cycle. On the transition out: if hold_full, load hold and go directly to START (zero idle cycles); else go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT), and wraps at each bit boundary. Every bit lasts exactly CLKS_PER_BIT cycles with no drift.
- Holding register drains on the same edge a new frame is loaded. data_ready rises the cycle after, so accept and drain never happen in the same cycle.
- busy = (state != IDLE) || hold_full, registered.
- The frame is latched at load time; data_byte changes after acceptance have no effect on the frame in flight.
- Frame length in cycles: (10 + (PARITY!=0) + (STOP_BITS-1)) * CLKS_PER_BIT.

Test Plan:
- CLKS_PER_BIT=8, 100 ns clock, PARITY=0, STOP_BITS=1; send 0x55 -> data_line 0,1,0,1,0,1,0,1,0,1, each level exactly 800 ns. tx_done pulses once at cycle 80 after the start bit begins; busy falls the next cycle; data_line stays 1.
- Back-to-back: present 0xA5, then 0x3C while the first is shifting -> data_ready low from the accept of 0x3C until the 0xA5 stop bit ends. The 0x3C start bit begins on the cycle right after the 0xA5 stop bit (160 cycles total, no gap). Two tx_done pulses, 80 cycles apart.
- PARITY=1 with 0x07 -> parity bit 1. PARITY=2 with 0x07 -> parity bit 0. Frame is 88 cycles. STOP_BITS=2 with 0x00 -> stop high for 16 cycles, frame is 88 cycles.
- Assert rst at cycle 30 of a 0xFF frame -> data_line=1 within the same cycle, data_ready=1, busy=0. No tx_done. The next accepted byte 0x12 transmits correctly from a fresh start bit.
- Loopback into uart_rx_module at CLKS_PER_BIT=8: send 0x00, 0xFF, 0x81, 0x5A back to back -> data_flag fires 4 times with data_byte matching in order.
- Hold data_valid=1 constantly with an incrementing byte counter -> exactly one byte accepted per frame, none lost or duplicated, over 16 frames.
